muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle integer multiply/divide unit that serves the MUL, MULTU, DIV and DIVU requests raised by the pipeline's instruction decode and control logic.
- Accepts a one-hot operation request with two operands.
- Raises `mul_busy` or `div_busy` while it iterates, so the requesting instruction stalls.
- Presents the 64-bit HI/LO result in the cycle busy drops, which is the cycle the pipeline commits the register-file or HI/LO write.
- Sits in the EX stage beside the ALU; its `hi`/`lo` outputs feed the HI/LO input selects.

## Interface
Parameters
- `WIDTH`, 32: operand width; iteration count equals `WIDTH`.

Ports
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `op_mul`  in  1  signed multiply request (result in `lo`).
- `op_multu`  in  1  unsigned multiply request.
- `op_div`  in  1  signed divide request.
- `op_divu`  in  1  unsigned divide request.
- `a`  in  WIDTH  rs operand (multiplicand / dividend).
- `b`  in  WIDTH  rt operand (multiplier / divisor).
- `stall`  in  1  pipeline held by another cause; DONE is held while set.
- `mul_busy`  out  1  multiply in progress; the instruction must not write.
- `div_busy`  out  1  divide in progress.
- `hi`  out  WIDTH  product high / remainder.
- `lo`  out  WIDTH  product low / quotient.

## Operation
- States: IDLE, RUN, DONE.
- Request priority when several `op_*` are set: MUL > MULTU > DIV > DIVU. Multiple requests are a decoder error, but the behaviour is still defined.

IDLE
- On any request, latch the op class, the operand sign flags, |a| and |b| (signed ops) or raw values (unsigned ops), and clear the counter. Go to RUN.

RUN
- Multiply: one shift-add per cycle on magnitudes into a 2·WIDTH accumulator.
- Divide: one restoring shift-subtract per cycle on magnitudes.
- The counter increments each cycle. When counter == WIDTH−1, load `hi`/`lo` with the sign-corrected result and go to DONE.

Sign correction
- Product is negated if sign(a) ≠ sign(b).
- Quotient is negated if sign(a) ≠ sign(b).
- Remainder takes sign(a).

Divide by zero (b == 0), all decided
- DIVU: `lo` = all ones, `hi` = a.
- DIV: `lo` = all ones, `hi` = a (raw, not sign-corrected).

Overflow
- DIV 0x8000_0000 / 0xFFFF_FFFF gives `lo` = 0x8000_0000, `hi` = 0. This falls out naturally from the magnitude path.

DONE
- Busy is low and `hi`/`lo` are valid.
- If `stall` = 1, remain in DONE. Otherwise go to IDLE.
- A request seen in DONE is not started; it is started from IDLE in the following cycle.

Busy outputs (combinational)
- `mul_busy` = (IDLE ∧ (op_mul ∨ op_multu)) ∨ (RUN ∧ class == MUL).
- `div_busy` is the divide analogue.
- Both are 0 in DONE and while `rst` is asserted.

Results
- `hi`/`lo` hold their last result until the next DONE load. They are never cleared by the start of a new operation.

## Timing
- Reset: state IDLE, counter 0, `hi` = `lo` = 0, busy = 0.
- Reset takes effect immediately, including mid-RUN; the operation is discarded.
- Latency, with the request first seen in cycle 0 (IDLE):
  - Busy is high in cycles 0..WIDTH.
  - DONE, with busy low and the result valid, is cycle WIDTH+1 (cycle 33 for 32 bits).
- Back-to-back ops: the next request can start at the earliest in cycle WIDTH+2. Busy for it asserts combinationally in that cycle.
- Requests must remain asserted while busy is high. Deasserting a request mid-RUN does not abort the operation.
- Operands are sampled only in IDLE. Changes to `a`/`b` during RUN are ignored.

## Structure
Shared package `mdu_pkg`
- State enum {IDLE, RUN, DONE}.
- Op class enum {MUL, MULTU, DIV, DIVU}.
- `DIV0_Q` constant (all ones).

Sub-module
- One natural sub-module: `div_iter`, a single restoring-division step (remainder, quotient-bit outputs), instantiated once in the RUN datapath.
- The multiply step stays inline.

## Test plan
- MULTU a = 0xFFFF_FFFF, b = 0xFFFF_FFFF:
  - `mul_busy` high for cycles 0–32, low in cycle 33.
  - `hi` = 0xFFFF_FFFE, `lo` = 0x0000_0001.
- MUL a = −7 (0xFFFF_FFF9), b = 6 → `lo` = 0xFFFF_FFD6, `hi` = 0xFFFF_FFFF; `div_busy` stays 0 throughout.
- DIV a = −7, b = 2 → `lo` = 0xFFFF_FFFD, `hi` = 0xFFFF_FFFF.
- DIVU a = 100, b = 0 → `lo` = 0xFFFF_FFFF, `hi` = 100.
- DIV 0x8000_0000 / 0xFFFF_FFFF → `lo` = 0x8000_0000, `hi` = 0.
- Control behaviour:
  - `stall` = 1 in DONE for 3 cycles: the state holds and the result stays stable, then returns to IDLE.
  - `rst` pulsed at cycle 10 of a DIVU: busy drops immediately, `hi` = `lo` = 0, and a new MULTU started afterwards completes correctly.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MUL,
        MULTU,
        DIV,
        DIVU
    } op_cls_t;

    localparam logic [63:0] DIV0_Q = '1;

    function automatic logic is_mul(op_cls_t cls);
        return (cls == MUL) || (cls == MULTU);
    endfunction

endpackage

// File: rtl/div_iter.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt_c,
    output logic             q_bit_c
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted   = {rem, dividend_bit};
        diff      = shifted - {1'b0, divisor};
        q_bit_c   = (shifted >= {1'b0, divisor});
        rem_nxt_c = q_bit_c ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/MULTU/DIV/DIVU unit: WIDTH magnitude steps, sign fix-up on the last step.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_mul,
    input  logic             op_multu,
    input  logic             op_div,
    input  logic             op_divu,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             stall,
    output logic             mul_busy,
    output logic             div_busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned W2    = 2 * WIDTH;

    state_t            state, state_nxt;
    op_cls_t           cls, req_cls;
    logic [CNT_W-1:0]  cnt;
    logic [W2-1:0]     acc, acc_nxt;
    logic [WIDTH-1:0]  opnd;
    logic              sign_a, neg_res, b_zero;

    logic              req_any, req_signed, req_sa, req_sb, last;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [WIDTH:0]    mul_add, mul_sum;
    logic [WIDTH-1:0]  div_rem;
    logic              div_q;
    logic [W2-1:0]     prod;
    logic [WIDTH-1:0]  q_mag, r_mag, res_hi, res_lo;

    // Request decode with fixed priority MUL > MULTU > DIV > DIVU
    always_comb begin
        req_any = op_mul | op_multu | op_div | op_divu;
        if (op_mul)        req_cls = MUL;
        else if (op_multu) req_cls = MULTU;
        else if (op_div)   req_cls = DIV;
        else               req_cls = DIVU;
        req_signed = (req_cls == MUL) || (req_cls == DIV);
        req_sa     = req_signed & a[WIDTH-1];
        req_sb     = req_signed & b[WIDTH-1];
        a_mag      = req_sa ? -a : a;
        b_mag      = req_sb ? -b : b;
        last       = (cnt == CNT_W'(WIDTH - 1));
    end

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .rem          (acc[W2-1:WIDTH]),
        .dividend_bit (acc[WIDTH-1]),
        .divisor      (opnd),
        .rem_nxt_c    (div_rem),
        .q_bit_c      (div_q)
    );

    // Multiply: {partial product, remaining multiplier bits} shifted right each step.
    // Divide: {remainder, dividend shifting out / quotient shifting in}.
    always_comb begin
        mul_add = acc[0] ? {1'b0, opnd} : '0;
        mul_sum = {1'b0, acc[W2-1:WIDTH]} + mul_add;
        if (is_mul(cls)) acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        else             acc_nxt = {div_rem, acc[WIDTH-2:0], div_q};
    end

    // Sign correction applied to the final step's magnitudes
    always_comb begin
        prod  = neg_res ? -acc_nxt : acc_nxt;
        q_mag = acc_nxt[WIDTH-1:0];
        r_mag = acc_nxt[W2-1:WIDTH];
        if (is_mul(cls)) begin
            res_hi = prod[W2-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else begin
            res_hi = sign_a ? -r_mag : r_mag;
            res_lo = b_zero ? DIV0_Q[WIDTH-1:0] : (neg_res ? -q_mag : q_mag);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = RUN;
            RUN:     if (last)    state_nxt = DONE;
            DONE:    if (!stall)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Busy is combinational so the requesting instruction stalls in its first cycle
    always_comb begin
        mul_busy = 1'b0;
        div_busy = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    mul_busy = op_mul | op_multu;
                    div_busy = op_div | op_divu;
                end
                RUN: begin
                    mul_busy = is_mul(cls);
                    div_busy = !is_mul(cls);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cls     <= MUL;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            sign_a  <= 1'b0;
            neg_res <= 1'b0;
            b_zero  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else if (state == IDLE) begin
            if (req_any) begin
                cls     <= req_cls;
                cnt     <= '0;
                sign_a  <= req_sa;
                neg_res <= req_sa ^ req_sb;
                b_zero  <= (b == '0);
                if (is_mul(req_cls)) begin
                    acc  <= {{WIDTH{1'b0}}, b_mag};
                    opnd <= a_mag;
                end else begin
                    acc  <= {{WIDTH{1'b0}}, a_mag};
                    opnd <= b_mag;
                end
            end
        end else if (state == RUN) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;

    localparam int unsigned WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              op_mul, op_multu, op_div, op_divu;
    logic [WIDTH-1:0]  a, b;
    logic              stall;
    logic              mul_busy, div_busy;
    logic [WIDTH-1:0]  hi, lo;

    int n_chk  = 0;
    int n_pass = 0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_mul   (op_mul),
        .op_multu (op_multu),
        .op_div   (op_div),
        .op_divu  (op_divu),
        .a        (a),
        .b        (b),
        .stall    (stall),
        .mul_busy (mul_busy),
        .div_busy (div_busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    // op: 0 MUL, 1 MULTU, 2 DIV, 3 DIVU
    function automatic void ref_model(input int op, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] rh, output logic [31:0] rl);
        longint sp;
        logic [63:0] up;
        int sx, sy;
        sx = int'(x);
        sy = int'(y);
        case (op)
            0: begin
                sp = longint'(sx) * longint'(sy);
                {rh, rl} = 64'(sp);
            end
            1: begin
                up = {32'd0, x} * {32'd0, y};
                {rh, rl} = up;
            end
            2: begin
                if (y == 32'd0) begin
                    rl = 32'hFFFF_FFFF; rh = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000; rh = 32'd0;
                end else begin
                    rl = 32'(sx / sy); rh = 32'(sx % sy);
                end
            end
            default: begin
                if (y == 32'd0) begin
                    rl = 32'hFFFF_FFFF; rh = x;
                end else begin
                    rl = x / y; rh = x % y;
                end
            end
        endcase
    endfunction

    task automatic set_ops(input int op);
        op_mul   = (op == 0);
        op_multu = (op == 1);
        op_div   = (op == 2);
        op_divu  = (op == 3);
    endtask

    task automatic clear_ops();
        op_mul = 0; op_multu = 0; op_div = 0; op_divu = 0;
    endtask

    // Issue one op from IDLE, check latency, busy, result, and an optional DONE stall
    task automatic run_op(input int op, input logic [31:0] x, input logic [31:0] y, input int stall_n);
        logic [31:0] eh, el;
        int cyc;
        logic other, mine;
        ref_model(op, x, y, eh, el);
        @(negedge clk);
        a = x; b = y; set_ops(op);
        #1;
        mine = (op < 2) ? mul_busy : div_busy;
        check_val($sformatf("busy_c0 op%0d", op), 64'(mine), 64'd1);
        cyc = 0;
        other = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                a = $urandom; b = $urandom;
            end
            other = other | ((op < 2) ? div_busy : mul_busy);
            mine  = (op < 2) ? mul_busy : div_busy;
            if (!mine) break;
        end
        check_val($sformatf("latency op%0d", op), 64'(cyc), 64'(WIDTH + 1));
        check_val($sformatf("other_busy op%0d", op), 64'(other), 64'd0);
        check_val($sformatf("result op%0d a=%h b=%h", op, x, y), {hi, lo}, {eh, el});
        clear_ops();
        if (stall_n > 0) begin
            stall = 1'b1;
            set_ops(1);
            repeat (stall_n) begin
                @(negedge clk);
                check_val("stall_busy", 64'(mul_busy), 64'd0);
                check_val("stall_hold", {hi, lo}, {eh, el});
            end
            stall = 1'b0;
            @(negedge clk);
            check_val("stall_release_busy", 64'(mul_busy), 64'd1);
            clear_ops();
        end
    endtask

    initial begin
        logic [31:0] rx, ry;
        int rop;
        rst = 1'b1;
        stall = 1'b0;
        a = '0; b = '0;
        set_ops(0);
        op_div = 1'b1;
        repeat (2) @(negedge clk);
        check_val("reset_mul_busy", 64'(mul_busy), 64'd0);
        check_val("reset_div_busy", 64'(div_busy), 64'd0);
        check_val("reset_hilo", {hi, lo}, 64'd0);
        clear_ops();
        rst = 1'b0;

        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(0, 32'hFFFF_FFF9, 32'd6, 0);
        run_op(2, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3, 32'd100, 32'd0, 0);
        run_op(2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2, 32'hFFFF_FF9C, 32'd0, 0);
        run_op(0, 32'd12345, 32'hFFFF_FC00, 3);

        // Reset mid-divide with the request still held
        @(negedge clk);
        set_ops(3);
        a = 32'hDEAD_BEEF; b = 32'd7;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_mid_div_busy", 64'(div_busy), 64'd0);
        check_val("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_ops();
        run_op(1, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        for (int i = 0; i < 20; i++) begin
            rop = $urandom_range(0, 3);
            rx  = $urandom;
            ry  = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: ry = 32'hFFFF_FFFF;
                2: ry = 32'($urandom_range(1, 15));
                3: rx = 32'h8000_0000;
                default: ;
            endcase
            run_op(rop, rx, ry, (i % 7 == 3) ? 2 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
